// File: rtl/fifo_flex.sv
// fifo_flex: parametrised count-based synchronous FIFO with optional first-word-fall-through,
// occupancy, programmable almost-full/almost-empty levels and sticky overflow/underflow flags.
// Latency: a write is counted next cycle; registered read data follows the pop by one cycle
// (FWFT=0) or the head is shown combinationally (FWFT=1).
// Backpressure: a write while full is dropped unless a read frees the slot in the same cycle;
// a read while empty is ignored. Both raise a sticky error flag.
module fifo_flex #(
  parameter int WORD_SIZE = 6,
  parameter int MEM_SIZE  = 8,
  parameter int PTR_L     = 3,
  parameter int FWFT      = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_wr,
  input  logic [WORD_SIZE-1:0] fifo_data_in,
  input  logic                 fifo_rd,
  input  logic [PTR_L:0]       full_threshold,
  input  logic [PTR_L:0]       empty_threshold,
  input  logic                 error_clr,
  output logic [WORD_SIZE-1:0] fifo_data_out,
  output logic                 data_valid,
  output logic [PTR_L:0]       fifo_count,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 error
);

  localparam logic [PTR_L:0] FULL_CNT = (PTR_L+1)'(MEM_SIZE);

  logic [WORD_SIZE-1:0] mem_q [MEM_SIZE];
  logic [PTR_L-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_L-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_L:0]       count_q, count_d;
  logic [WORD_SIZE-1:0] dout_q, dout_d;
  logic                 dvld_q, dvld_d;
  logic                 ovf_q, ovf_d;
  logic                 udf_q, udf_d;
  logic                 wr_acc, rd_acc;

  // Status flags all derive from the registered occupancy; thresholds act with no delay.
  assign fifo_full    = (count_q == FULL_CNT);
  assign fifo_empty   = (count_q == '0);
  assign almost_full  = (count_q >= full_threshold);
  assign almost_empty = (count_q <= empty_threshold);
  assign fifo_count   = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
  assign error        = ovf_q | udf_q;

  // A read in the same cycle frees a slot, so a full FIFO still takes a write alongside it.
  assign wr_acc = fifo_wr && (!fifo_full || fifo_rd);
  assign rd_acc = fifo_rd && !fifo_empty;

  // Next-state for pointers, occupancy, registered read port and sticky error flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    dvld_d   = 1'b0;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_L'(1);
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_L'(1);
      dout_d   = mem_q[rd_ptr_q];
      dvld_d   = 1'b1;
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (PTR_L+1)'(1);
      2'b01:   count_d = count_q - (PTR_L+1)'(1);
      default: count_d = count_q;
    endcase
    // Clear first so that an error event in the same cycle keeps its flag set.
    if (error_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (fifo_wr && fifo_full && !fifo_rd) ovf_d = 1'b1;
    if (fifo_rd && fifo_empty)            udf_d = 1'b1;
  end

  // Control state register; reset discards all stored words.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      dvld_q   <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      dvld_q   <= dvld_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array: written on accepted writes only, contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) mem_q[wr_ptr_q] <= fifo_data_in;
  end

  // Read port: head shown directly in fall-through mode, else the registered pop result.
  if (FWFT != 0) begin : g_fwft
    assign fifo_data_out = mem_q[rd_ptr_q];
    assign data_valid    = !fifo_empty;
  end else begin : g_reg
    assign fifo_data_out = dout_q;
    assign data_valid    = dvld_q;
  end

endmodule

// File: tb/tb_fifo_flex.sv
// tb_fifo_flex: directed bench for fifo_flex with a registered-read instance (a_*) and a
// fall-through instance (b_*). A queue model tracks contents; popped words go to an
// expected-output queue that is compared when the DUT presents read data.
module tb_fifo_flex;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Registered-read instance
  logic       a_rst = 1'b1, a_wr = 1'b0, a_rd = 1'b0, a_clr = 1'b0;
  logic [5:0] a_din = '0;
  logic [3:0] a_fth = 4'd6, a_eth = 4'd2;
  logic [5:0] a_dout;
  logic [3:0] a_cnt;
  logic       a_dvld, a_full, a_empty, a_af, a_ae, a_ovf, a_udf, a_err;

  // Fall-through instance
  logic       b_rst = 1'b1, b_wr = 1'b0, b_rd = 1'b0, b_clr = 1'b0;
  logic [5:0] b_din = '0;
  logic [3:0] b_fth = 4'd8, b_eth = 4'd0;
  logic [5:0] b_dout;
  logic [3:0] b_cnt;
  logic       b_dvld, b_full, b_empty, b_af, b_ae, b_ovf, b_udf, b_err;

  fifo_flex #(.WORD_SIZE(6), .MEM_SIZE(8), .PTR_L(3), .FWFT(0)) dut_a (
    .clk(clk), .reset(a_rst), .fifo_wr(a_wr), .fifo_data_in(a_din), .fifo_rd(a_rd),
    .full_threshold(a_fth), .empty_threshold(a_eth), .error_clr(a_clr),
    .fifo_data_out(a_dout), .data_valid(a_dvld), .fifo_count(a_cnt),
    .fifo_full(a_full), .fifo_empty(a_empty), .almost_full(a_af), .almost_empty(a_ae),
    .overflow(a_ovf), .underflow(a_udf), .error(a_err)
  );

  fifo_flex #(.WORD_SIZE(6), .MEM_SIZE(8), .PTR_L(3), .FWFT(1)) dut_b (
    .clk(clk), .reset(b_rst), .fifo_wr(b_wr), .fifo_data_in(b_din), .fifo_rd(b_rd),
    .full_threshold(b_fth), .empty_threshold(b_eth), .error_clr(b_clr),
    .fifo_data_out(b_dout), .data_valid(b_dvld), .fifo_count(b_cnt),
    .fifo_full(b_full), .fifo_empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
    .overflow(b_ovf), .underflow(b_udf), .error(b_err)
  );

  logic [5:0] aq[$];    // model contents, instance a
  logic [5:0] aexp[$];  // words popped, awaiting the registered output
  logic [5:0] bq[$];    // model contents, instance b
  logic a_movf = 1'b0, a_mudf = 1'b0, b_movf = 1'b0, b_mudf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic status_a();
    chk("a_count",  32'(a_cnt),  32'(aq.size()));
    chk("a_full",   32'(a_full), 32'(aq.size() == 8));
    chk("a_empty",  32'(a_empty), 32'(aq.size() == 0));
    chk("a_afull",  32'(a_af),   32'(aq.size() >= int'(a_fth)));
    chk("a_aempty", 32'(a_ae),   32'(aq.size() <= int'(a_eth)));
    chk("a_ovf",    32'(a_ovf),  32'(a_movf));
    chk("a_udf",    32'(a_udf),  32'(a_mudf));
    chk("a_err",    32'(a_err),  32'(a_movf | a_mudf));
  endtask

  task automatic status_b();
    chk("b_count", 32'(b_cnt),   32'(bq.size()));
    chk("b_full",  32'(b_full),  32'(bq.size() == 8));
    chk("b_empty", 32'(b_empty), 32'(bq.size() == 0));
    chk("b_valid", 32'(b_dvld),  32'(bq.size() != 0));
    if (bq.size() != 0) chk("b_head", 32'(b_dout), 32'(bq[0]));
    chk("b_ovf", 32'(b_ovf), 32'(b_movf));
    chk("b_udf", 32'(b_udf), 32'(b_mudf));
  endtask

  // One clock of instance a; called at a falling edge, returns at the next falling edge.
  task automatic cyc_a(input logic wr, input logic [5:0] d, input logic rd, input logic clr);
    bit full_b, empty_b, wacc, racc;
    full_b  = (aq.size() == 8);
    empty_b = (aq.size() == 0);
    wacc = wr && (!full_b || rd);
    racc = rd && !empty_b;
    a_wr = wr; a_din = d; a_rd = rd; a_clr = clr;
    @(posedge clk);
    if (racc) aexp.push_back(aq.pop_front());
    if (wacc) aq.push_back(d);
    if (clr) begin a_movf = 1'b0; a_mudf = 1'b0; end
    if (wr && full_b && !rd) a_movf = 1'b1;
    if (rd && empty_b)       a_mudf = 1'b1;
    @(negedge clk);
    a_wr = 1'b0; a_rd = 1'b0; a_clr = 1'b0;
    chk("a_valid", 32'(a_dvld), 32'(racc));
    if (racc) chk("a_dout", 32'(a_dout), 32'(aexp.pop_front()));
    status_a();
  endtask

  task automatic cyc_b(input logic wr, input logic [5:0] d, input logic rd);
    bit full_b, empty_b, wacc, racc;
    full_b  = (bq.size() == 8);
    empty_b = (bq.size() == 0);
    wacc = wr && (!full_b || rd);
    racc = rd && !empty_b;
    b_wr = wr; b_din = d; b_rd = rd;
    @(posedge clk);
    if (racc) void'(bq.pop_front());
    if (wacc) bq.push_back(d);
    if (wr && full_b && !rd) b_movf = 1'b1;
    if (rd && empty_b)       b_mudf = 1'b1;
    @(negedge clk);
    b_wr = 1'b0; b_rd = 1'b0;
    status_b();
  endtask

  task automatic rst_a();
    a_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_rst = 1'b0;
    aq.delete(); aexp.delete();
    a_movf = 1'b0; a_mudf = 1'b0;
    chk("a_rst_dout",  32'(a_dout), 32'h0);
    chk("a_rst_valid", 32'(a_dvld), 32'h0);
    status_a();
  endtask

  task automatic rst_b();
    b_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_rst = 1'b0;
    bq.delete();
    b_movf = 1'b0; b_mudf = 1'b0;
    status_b();
  endtask

  initial begin
    @(negedge clk);
    rst_a();
    rst_b();

    // Fill with 0x01..0x08; thresholds 6/2 are checked on every step.
    for (int i = 1; i <= 8; i++) cyc_a(1'b1, 6'(i), 1'b0, 1'b0);

    // Threshold change acts without a clock.
    a_fth = 4'd8; #1; chk("a_afull_comb_hi", 32'(a_af), 32'h1);
    a_fth = 4'd9; #1; chk("a_afull_comb_lo", 32'(a_af), 32'h0);
    a_fth = 4'd6; #1;
    a_eth = 4'd8; #1; chk("a_aempty_comb", 32'(a_ae), 32'h1);
    a_eth = 4'd2; #1;

    // Write while full with no read: dropped, overflow sticky.
    cyc_a(1'b1, 6'h3F, 1'b0, 1'b0);
    cyc_a(1'b0, 6'h00, 1'b0, 1'b0);
    cyc_a(1'b0, 6'h00, 1'b0, 1'b1);

    // Full with read and write: oldest out, new word goes to the tail.
    cyc_a(1'b1, 6'h20, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cyc_a(1'b0, 6'h00, 1'b1, 1'b0);

    // Empty with read and write: write taken, read rejected, underflow set.
    cyc_a(1'b1, 6'h15, 1'b1, 1'b0);
    cyc_a(1'b0, 6'h00, 1'b1, 1'b0);
    // Clear coincident with a new underflow: flag stays set.
    cyc_a(1'b0, 6'h00, 1'b1, 1'b1);
    cyc_a(1'b0, 6'h00, 1'b0, 1'b1);

    // Five words stored with overflow set, then reset mid-operation.
    for (int i = 0; i < 8; i++) cyc_a(1'b1, 6'(8'h30 + i), 1'b0, 1'b0);
    cyc_a(1'b1, 6'h3E, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc_a(1'b0, 6'h00, 1'b1, 1'b0);
    rst_a();
    cyc_a(1'b1, 6'h2A, 1'b0, 1'b0);
    cyc_a(1'b1, 6'h2B, 1'b0, 1'b0);
    cyc_a(1'b0, 6'h00, 1'b1, 1'b0);
    cyc_a(1'b0, 6'h00, 1'b1, 1'b0);
    cyc_a(1'b0, 6'h00, 1'b0, 1'b0);

    // Fall-through: head visible the cycle after the write, before any read.
    cyc_b(1'b1, 6'h0A, 1'b0);
    chk("b_fwft_first_dout",  32'(b_dout), 32'h0A);
    chk("b_fwft_first_valid", 32'(b_dvld), 32'h1);
    // Interleaved traffic; 21 writes wrap the pointers twice.
    for (int i = 0; i < 20; i++)
      cyc_b(1'b1, 6'((i * 5 + 3) & 63), (bq.size() >= 2));
    while (bq.size() != 0) cyc_b(1'b0, 6'h00, 1'b1);
    cyc_b(1'b0, 6'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
